// File: rtl/serial_geq_ctrl.sv
// serial_geq_ctrl: MSB-first 2-bit-per-cycle a >= b comparator with start/done handshake.
// Optional EARLY_EXIT_EN: finish on the first differing slice instead of running all W/2 slices.
module serial_geq_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         done,
  output logic         ageqb
);
  localparam int N  = W / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
`ifdef EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  if (W < 2 || W % 2 != 0) begin : g_bad_w
    $error("serial_geq_ctrl: W must be even and >= 2");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] sra, srb;
  logic [IW-1:0] idx;
  logic decided, res;
  logic [1:0] sa, sb;
  logic gt, last, early, dec_n, res_n;
  always_comb begin
    sa    = sra[W-1 -: 2];
    sb    = srb[W-1 -: 2];
    gt    = sa > sb;
    last  = idx == IW'(N - 1);
    early = EE && !decided && (sa != sb);
    dec_n = decided || (sa != sb);
    res_n = decided ? res : gt;
    state_n = state;
    case (state)
      IDLE:    state_n = start ? RUN : IDLE;
      RUN:     state_n = (last || early) ? DONE : RUN;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign ready = state == IDLE;
  assign done  = state == DONE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sra     <= '0;
      srb     <= '0;
      idx     <= '0;
      decided <= 1'b0;
      res     <= 1'b0;
      ageqb   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        sra     <= a;
        srb     <= b;
        idx     <= '0;
        decided <= 1'b0;
        res     <= 1'b0;
        ageqb   <= 1'b0;
      end else if (state == RUN) begin
        decided <= dec_n;
        res     <= res_n;
        sra     <= sra << 2;
        srb     <= srb << 2;
        idx     <= last ? idx : idx + 1'b1;
        // no differing slice at all means a == b
        if (state_n == DONE) ageqb <= dec_n ? res_n : 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_serial_geq_ctrl.sv
// tb_serial_geq_ctrl: table, corner-case and random checks of serial_geq_ctrl (W=8).
module tb_serial_geq_ctrl;
`ifdef EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n, start;
  logic [7:0] a, b;
  logic ready, done, ageqb;
  int checks = 0;
  int errors = 0;
  serial_geq_ctrl #(.W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b),
    .ready(ready), .done(done), .ageqb(ageqb)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       q;
  } vec_t;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic int lat_of(input logic [7:0] x, input logic [7:0] y);
    for (int i = 0; i < 4; i++)
      if (x[7-2*i -: 2] != y[7-2*i -: 2]) return EE ? i + 1 : 4;
    return 4;
  endfunction
  task automatic op(input logic [7:0] x, input logic [7:0] y, input logic q, input string nm);
    int n;
    chk({nm, "_ready"}, 32'(ready), 1);
    start = 1'b1; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); n = 0;
    while (!done && n < 20) begin
      chk({nm, "_busy"}, 32'(ready), 0);
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(lat_of(x, y)));
    chk({nm, "_q"}, 32'(ageqb), 32'(q));
    @(negedge clk);
    chk({nm, "_pulse"}, 32'(done), 0);
    chk({nm, "_idle"}, 32'(ready), 1);
    chk({nm, "_hold"}, 32'(ageqb), 32'(q));
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
  initial begin
    vec_t tbl[10];
    logic [7:0] ra, rb;
    int ndone, last_acc, k, prev_lat;
    logic prev_q;
    tbl = '{'{8'hA5, 8'hA5, 1'b1}, '{8'h40, 8'h80, 1'b0}, '{8'hFF, 8'hFE, 1'b1},
            '{8'h00, 8'h00, 1'b1}, '{8'h00, 8'hFF, 1'b0}, '{8'hFF, 8'h00, 1'b1},
            '{8'h7F, 8'h80, 1'b0}, '{8'h80, 8'h7F, 1'b1}, '{8'h01, 8'h02, 1'b0},
            '{8'h10, 8'h0F, 1'b1}};
    reset_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_q", 32'(ageqb), 0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) op(tbl[i].a, tbl[i].b, tbl[i].q, $sformatf("tbl%0d", i));
    // start held through RUN with new operands must not re-sample or re-trigger
    start = 1'b1; a = 8'h01; b = 8'h02;
    @(negedge clk);
    a = 8'hFF; ndone = 0;
    for (int i = 0; i < 4 && !done; i++) begin
      chk("hold_busy", 32'(ready), 0);
      @(negedge clk);
    end
    chk("hold_done", 32'(done), 1);
    chk("hold_q", 32'(ageqb), 0);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ndone += done ? 1 : 0;
      @(negedge clk);
    end
    chk("hold_one_pulse", 32'(ndone), 1);
    chk("hold_idle", 32'(ready), 1);
    // reset in the middle of RUN abandons the operation
    start = 1'b1; a = 8'hA5; b = 8'hA5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready), 1);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_q", 32'(ageqb), 0);
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      ndone += done ? 1 : 0;
      @(negedge clk);
    end
    chk("mid_rst_nodone", 32'(ndone), 0);
    op(8'h10, 8'h0F, 1'b1, "after_rst");
    // back-to-back with start held high
    start = 1'b1; last_acc = -1; k = 0; prev_q = 1'b0; prev_lat = 0;
    for (int cyc = 0; cyc < 60 && k <= 4; cyc++) begin
      if (done) chk("b2b_res", 32'(ageqb), 32'(prev_q));
      if (ready) begin
        if (k > 0) begin
          chk("b2b_interval", 32'(cyc - last_acc), 32'(prev_lat + 2));
          chk("b2b_hold", 32'(ageqb), 32'(prev_q));
        end
        if (k == 4) break;
        ra = 8'($urandom); rb = (k == 1) ? ra : 8'($urandom);
        a = ra; b = rb;
        prev_q = ra >= rb; prev_lat = lat_of(ra, rb); last_acc = cyc; k++;
      end
      @(negedge clk);
    end
    chk("b2b_count", 32'(k), 4);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      if (i % 5 == 0) rb = ra;
      if (i % 7 == 0) rb = ra ^ (8'h1 << (i % 8));
      op(ra, rb, ra >= rb, $sformatf("rnd%0d", i));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
